// File: rtl/timer_pkg.sv
// Keypad/timer shared definitions: key codes, digit limits and the key FSM state encoding.
// Also used by the display and timer blocks.
package timer_pkg;

    localparam logic [3:0] NO_KEY      = 4'hF;
    localparam logic [3:0] MAX_DIGIT   = 4'd9;
    localparam logic [2:0] MAX_NDIGITS = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_debouncer.sv
// Debounce timer for the keypad FSM. It restarts from zero or counts up while run is high.
// done is high once DEBOUNCE cycles have been counted.
module key_debouncer #(
    parameter int DEBOUNCE = 16,
    parameter int CNT_W    = 5
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart,
    input  logic run,
    output logic done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done = (cnt_q == CNT_W'(DEBOUNCE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (run && !done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_digit_entry.sv
// Keypad digit entry. Each debounced key press shifts one BCD digit into the MM:SS entry register.
// Optional macro DIGIT_LIMIT_EN: once four digits are held, further presses are dropped instead of shifted.
module keypad_digit_entry
    import timer_pkg::*;
#(
    parameter int DEBOUNCE = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enablen,
    input  logic [3:0]  digit,
    input  logic        validn,
    input  logic        clearn,
    output logic [15:0] bcd,
    output logic        digit_stb,
    output logic [2:0]  ndigits
);

    key_state_e  state_q, state_d;
    logic [3:0]  key_q, key_d;
    logic [15:0] bcd_q, bcd_d;
    logic [2:0]  nd_q, nd_d;
    logic        stb_q, stb_d;
    logic        restart, run, db_done, accept, shift_ok, key_valid;

    // A code above 9 is treated the same as no key.
    assign key_valid = !validn && (digit != NO_KEY) && (digit <= MAX_DIGIT);

    key_debouncer #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) u_debouncer (
        .clk     (clk),
        .resetn  (resetn),
        .restart (restart),
        .run     (run),
        .done    (db_done)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        restart = 1'b0;
        run     = 1'b0;
        accept  = 1'b0;
        // While the timer runs, park in REL_DB so a key held across enable must be released first.
        if (enablen) begin
            state_d = ST_REL_DB;
            restart = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    restart = 1'b1;
                    if (key_valid) begin
                        state_d = ST_PRESS_DB;
                        key_d   = digit;
                    end
                end
                ST_PRESS_DB: begin
                    if (!key_valid || (digit != key_q)) begin
                        state_d = ST_IDLE;
                        restart = 1'b1;
                    end else if (db_done) begin
                        accept  = 1'b1;
                        state_d = ST_HELD;
                    end else begin
                        run = 1'b1;
                    end
                end
                ST_HELD: begin
                    restart = 1'b1;
                    if (!key_valid) begin
                        state_d = ST_REL_DB;
                    end
                end
                ST_REL_DB: begin
                    if (key_valid) begin
                        state_d = ST_HELD;
                        restart = 1'b1;
                    end else if (db_done) begin
                        state_d = ST_IDLE;
                    end else begin
                        run = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_REL_DB;
                    restart = 1'b1;
                end
            endcase
        end
    end

`ifdef DIGIT_LIMIT_EN
    assign shift_ok = accept && (nd_q != MAX_NDIGITS);
`else
    assign shift_ok = accept;
`endif

    always_comb begin
        bcd_d = bcd_q;
        nd_d  = nd_q;
        stb_d = 1'b0;
        // Clear takes priority over an accept on the same edge.
        if (!clearn) begin
            bcd_d = '0;
            nd_d  = '0;
        end else if (shift_ok) begin
            bcd_d = {bcd_q[11:0], key_q};
            stb_d = 1'b1;
            if (nd_q != MAX_NDIGITS) begin
                nd_d = nd_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_REL_DB;
            key_q   <= NO_KEY;
            bcd_q   <= '0;
            nd_q    <= '0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            bcd_q   <= bcd_d;
            nd_q    <= nd_d;
            stb_q   <= stb_d;
        end
    end

    assign bcd       = bcd_q;
    assign ndigits   = nd_q;
    assign digit_stb = stb_q;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Self-checking bench for keypad_digit_entry. Expected digit results are queued by the stimulus.
// A monitor checks each digit_stb against the head of that queue.
module tb_keypad_digit_entry;

    localparam int D = 16;
    localparam logic [3:0] NOKEY = 4'hF;

    logic        clk = 1'b0;
    logic        resetn, enablen, validn, clearn;
    logic [3:0]  digit;
    logic [15:0] bcd;
    logic        digit_stb;
    logic [2:0]  ndigits;

    int checks  = 0;
    int errors  = 0;
    int stb_cnt = 0;
    int stb_ref;
    int lat;

    typedef struct packed {
        logic [15:0] bcd;
        logic [2:0]  nd;
    } exp_t;
    exp_t exp_q[$];

    keypad_digit_entry #(.DEBOUNCE(D), .CNT_W(5)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enablen   (enablen),
        .digit     (digit),
        .validn    (validn),
        .clearn    (clearn),
        .bcd       (bcd),
        .digit_stb (digit_stb),
        .ndigits   (ndigits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [15:0] b, input logic [2:0] n);
        exp_t e;
        e.bcd = b;
        e.nd  = n;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d, input int hold, input int rel);
        @(negedge clk);
        digit  = d;
        validn = 1'b0;
        repeat (hold) @(negedge clk);
        digit  = NOKEY;
        validn = 1'b1;
        repeat (rel) @(negedge clk);
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (digit_stb === 1'b1) begin
            stb_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got strobe with bcd=%h ndigits=%0d, expected none", bcd, ndigits);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_bcd", 32'(bcd), 32'(e.bcd));
                chk("strobe_ndigits", 32'(ndigits), 32'(e.nd));
            end
        end
    end

    initial begin
        resetn  = 1'b0;
        enablen = 1'b0;
        validn  = 1'b1;
        digit   = NOKEY;
        clearn  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bcd", 32'(bcd), 32'h0);
        chk("reset_stb", 32'(digit_stb), 32'h0);
        chk("reset_ndigits", 32'(ndigits), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        idle(2 * D);

        // Case 1: four digits 1,2,3,0.
        stb_ref = stb_cnt;
        push(16'h0001, 3'd1); press(4'd1, 3 * D, 2 * D);
        push(16'h0012, 3'd2); press(4'd2, 3 * D, 2 * D);
        push(16'h0123, 3'd3); press(4'd3, 3 * D, 2 * D);
        push(16'h1230, 3'd4); press(4'd0, 3 * D, 2 * D);
        chk("case1_bcd", 32'(bcd), 32'h1230);
        chk("case1_ndigits", 32'(ndigits), 32'd4);
        chk("case1_strobes", 32'(stb_cnt - stb_ref), 32'd4);

        // Case 3: a fifth digit.
        stb_ref = stb_cnt;
`ifdef DIGIT_LIMIT_EN
        press(4'd5, 3 * D, 2 * D);
        chk("case3_bcd", 32'(bcd), 32'h1230);
        chk("case3_strobes", 32'(stb_cnt - stb_ref), 32'd0);
`else
        push(16'h2305, 3'd4);
        press(4'd5, 3 * D, 2 * D);
        chk("case3_bcd", 32'(bcd), 32'h2305);
        chk("case3_strobes", 32'(stb_cnt - stb_ref), 32'd1);
`endif
        chk("case3_ndigits", 32'(ndigits), 32'd4);

        // Plain clear while idle.
        @(negedge clk); clearn = 1'b0;
        @(negedge clk); clearn = 1'b1;
        chk("clear_bcd", 32'(bcd), 32'h0);
        chk("clear_ndigits", 32'(ndigits), 32'd0);

        // Case 2: long hold, then bounce followed by a stable press.
        stb_ref = stb_cnt;
        push(16'h0007, 3'd1);
        press(4'd7, 10 * D, 2 * D);
        chk("case2_long_hold_strobes", 32'(stb_cnt - stb_ref), 32'd1);
        stb_ref = stb_cnt;
        push(16'h0078, 3'd2);
        digit = 4'd8;
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            validn = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        validn = 1'b0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (digit_stb === 1'b1) break;
        end
        chk("case2_latency", 32'(lat), 32'(D + 1));
        idle(3 * D);
        digit  = NOKEY;
        validn = 1'b1;
        idle(2 * D);
        chk("case2_bounce_strobes", 32'(stb_cnt - stb_ref), 32'd1);

        // Case 4: enable raised during press debounce, dropped with key still held.
        stb_ref = stb_cnt;
        @(negedge clk);
        digit  = 4'd4;
        validn = 1'b0;
        idle(5);
        enablen = 1'b1;
        idle(30);
        chk("case4_bcd_enabled", 32'(bcd), 32'h0078);
        enablen = 1'b0;
        idle(3 * D);
        digit  = NOKEY;
        validn = 1'b1;
        idle(2 * D);
        chk("case4_held_strobes", 32'(stb_cnt - stb_ref), 32'd0);
        chk("case4_bcd_after", 32'(bcd), 32'h0078);
        push(16'h0784, 3'd3);
        press(4'd4, 3 * D, 2 * D);
        chk("case4_repress_bcd", 32'(bcd), 32'h0784);

        // Case 5: clear on the accept edge of digit 9.
        stb_ref = stb_cnt;
        @(negedge clk);
        digit  = 4'd9;
        validn = 1'b0;
        idle(D);
        clearn = 1'b0;
        @(negedge clk);
        clearn = 1'b1;
        idle(2 * D);
        digit  = NOKEY;
        validn = 1'b1;
        idle(2 * D);
        chk("case5_bcd", 32'(bcd), 32'h0);
        chk("case5_ndigits", 32'(ndigits), 32'd0);
        chk("case5_strobes", 32'(stb_cnt - stb_ref), 32'd0);
        push(16'h0009, 3'd1);
        press(4'd9, 3 * D, 2 * D);
        chk("case5_repress_bcd", 32'(bcd), 32'h0009);

        // Case 6: invalid codes with validn low, then reset mid-debounce.
        stb_ref = stb_cnt;
        @(negedge clk);
        digit  = 4'hF;
        validn = 1'b0;
        idle(3 * D);
        digit = 4'hA;
        idle(3 * D);
        digit  = NOKEY;
        validn = 1'b1;
        idle(2);
        chk("case6_invalid_strobes", 32'(stb_cnt - stb_ref), 32'd0);
        chk("case6_invalid_bcd", 32'(bcd), 32'h0009);
        // From IDLE a valid press must debounce in the normal time.
        push(16'h0096, 3'd2);
        press(4'd6, 3 * D, 2 * D);
        chk("case6_after_invalid_bcd", 32'(bcd), 32'h0096);

        stb_ref = stb_cnt;
        @(negedge clk);
        digit  = 4'd3;
        validn = 1'b0;
        idle(5);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("case6_rst_bcd", 32'(bcd), 32'h0);
        chk("case6_rst_ndigits", 32'(ndigits), 32'd0);
        chk("case6_rst_stb", 32'(digit_stb), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        idle(3 * D);
        digit  = NOKEY;
        validn = 1'b1;
        idle(2 * D);
        chk("case6_rst_strobes", 32'(stb_cnt - stb_ref), 32'd0);
        chk("case6_rst_bcd_after", 32'(bcd), 32'h0);

        chk("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
